// File: rtl/flag_unit_pkg.sv
// rtl/flag_unit_pkg.sv - shared encodings for the NZCV flag producer
package flag_unit_pkg;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Bit positions inside the {N,Z,C,V} flags bus
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flag pipeline state: IDLE = nothing pending, PEND = pending awaits commit
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } flag_state_t;

endpackage

// File: rtl/flag_calc.sv
// rtl/flag_calc.sv - combinational NZCV from ALU operands, result and op
//
// Ports:
//   src_a, src_b  ALU operands (WIDTH)
//   result        ALU result for the op (WIDTH)
//   alu_control   ALU op (ADD/SUB/AND/ORR)
//   cv_prev       current effective {C,V}, passed through for logical ops
//   nzcv          computed flags {N,Z,C,V}
module flag_calc
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] result,
    input  logic [1:0]       alu_control,
    input  logic [1:0]       cv_prev,
    output logic [3:0]       nzcv
);

    logic a_msb;
    logic b_msb;
    logic r_msb;
    logic carry_add;
    logic carry_sub;

    assign a_msb = src_a[WIDTH-1];
    assign b_msb = src_b[WIDTH-1];
    assign r_msb = result[WIDTH-1];

    // a+b overflows WIDTH bits exactly when a > (2^WIDTH-1-b) == ~b
    assign carry_add = (src_a > ~src_b);
    // a+~b+1 carries out exactly when no borrow occurs, i.e. a >= b
    assign carry_sub = (src_a >= src_b);

    always_comb begin
        nzcv         = 4'b0000;
        nzcv[FLAG_N] = r_msb;
        nzcv[FLAG_Z] = (result == '0);
        case (alu_control)
            ALU_ADD: begin
                nzcv[FLAG_C] = carry_add;
                nzcv[FLAG_V] = (a_msb == b_msb) && (r_msb != a_msb);
            end
            ALU_SUB: begin
                nzcv[FLAG_C] = carry_sub;
                nzcv[FLAG_V] = (a_msb != b_msb) && (r_msb != a_msb);
            end
            default: begin
                // Logical ops never alter C,V
                nzcv[FLAG_C] = cv_prev[1];
                nzcv[FLAG_V] = cv_prev[0];
            end
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - NZCV producer with pending/committed flag pipeline
//
// Optional feature macro: FLAG_BYPASS_EN (Flags shows pending value, no hazard).
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   SrcA, SrcB    ALU operands; ALUResult ALU result; ALUControl ALU op
//   FlagWrite     [1] update N,Z; [0] update C,V
//   CondEx, Valid E-stage instruction passed its condition / is real
//   Stall, Flush  hold pipeline / discard pending update
//   Flags         {N,Z,C,V} for the condition checker
//   FlagsHazard   pending update not yet visible on Flags
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [1:0]       ALUControl,
    input  logic [1:0]       FlagWrite,
    input  logic             CondEx,
    input  logic             Valid,
    input  logic             Stall,
    input  logic             Flush,
    output logic [3:0]       Flags,
    output logic             FlagsHazard
);

    flag_state_t state;
    logic [3:0]  committed;
    logic [3:0]  pending;
    logic [3:0]  effective;
    logic [3:0]  calc_nzcv;
    logic [3:0]  merged;
    logic        we;

    // Newest architectural flags: an uncommitted update shadows committed
    assign effective = (state == ST_PEND) ? pending : committed;

    flag_calc #(.WIDTH(WIDTH)) u_calc (
        .src_a       (SrcA),
        .src_b       (SrcB),
        .result      (ALUResult),
        .alu_control (ALUControl),
        .cv_prev     (effective[FLAG_C:FLAG_V]),
        .nzcv        (calc_nzcv)
    );

    assign merged[FLAG_N:FLAG_Z] = FlagWrite[1] ? calc_nzcv[FLAG_N:FLAG_Z]
                                                : effective[FLAG_N:FLAG_Z];
    assign merged[FLAG_C:FLAG_V] = FlagWrite[0] ? calc_nzcv[FLAG_C:FLAG_V]
                                                : effective[FLAG_C:FLAG_V];

    assign we = Valid & CondEx & (|FlagWrite) & ~Stall & ~Flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            committed <= RST_FLAGS;
            pending   <= RST_FLAGS;
            state     <= ST_IDLE;
        end else if (Flush) begin
            // Pending update dropped; committed never advances on a flush,
            // stalled or not. The stale pending value is unobservable in IDLE.
            state <= ST_IDLE;
        end else if (!Stall) begin
            case (state)
                ST_IDLE: begin
                    if (we) begin
                        pending <= merged;
                        state   <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    committed <= pending;
                    if (we) begin
                        pending <= merged;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FLAG_BYPASS_EN
    assign Flags       = effective;
    assign FlagsHazard = 1'b0;
`else
    assign Flags       = committed;
    assign FlagsHazard = (state == ST_PEND);
`endif

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - self-checking bench for flag_unit against a behavioural model
module tb_flag_unit;
    import flag_unit_pkg::*;

    localparam logic [3:0] RST = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] SrcA, SrcB, ALUResult;
    logic [1:0]  ALUControl, FlagWrite;
    logic        CondEx, Valid, Stall, Flush;
    logic [3:0]  Flags;
    logic        FlagsHazard;

    int checks = 0;
    int errors = 0;

    // Behavioural model: committed flags plus an optional not-yet-committed update
    logic [3:0] m_comm = RST;
    logic [3:0] m_pend = RST;
    bit         m_pv   = 1'b0;

    always #5 clk = ~clk;

    flag_unit #(.WIDTH(32), .RST_FLAGS(RST)) dut (
        .clk         (clk),
        .reset       (reset),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .ALUResult   (ALUResult),
        .ALUControl  (ALUControl),
        .FlagWrite   (FlagWrite),
        .CondEx      (CondEx),
        .Valid       (Valid),
        .Stall       (Stall),
        .Flush       (Flush),
        .Flags       (Flags),
        .FlagsHazard (FlagsHazard)
    );

    function automatic logic [3:0] ref_nzcv(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] r,
                                            input logic [1:0] cv_old);
        longint sa, sb, s;
        logic   n, z, c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = r[31];
        z  = (r == 32'd0);
        c  = cv_old[1];
        v  = cv_old[0];
        if (op == ALU_ADD) begin
            c = ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == ALU_SUB) begin
            c = (a >= b);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {n, z, c, v};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: drive inputs, advance the model across
    // the next rising edge, then compare on the following falling edge.
    task automatic step(input string tag, input logic rst, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] fw,
                        input logic ce, input logic vld, input logic stl, input logic fl);
        logic [3:0] eff, nw, mg, exp_flags;
        logic [31:0] r;
        bit wr, exp_haz;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            default: r = a | b;
        endcase
        reset = rst; SrcA = a; SrcB = b; ALUResult = r; ALUControl = op;
        FlagWrite = fw; CondEx = ce; Valid = vld; Stall = stl; Flush = fl;

        eff = m_pv ? m_pend : m_comm;
        nw  = ref_nzcv(op, a, b, r, eff[1:0]);
        mg  = {fw[1] ? nw[3:2] : eff[3:2], fw[0] ? nw[1:0] : eff[1:0]};
        wr  = vld && ce && (fw != 2'b00) && !stl && !fl;
        if (rst) begin
            m_comm = RST; m_pend = RST; m_pv = 1'b0;
        end else if (fl) begin
            m_pv = 1'b0;
        end else if (!stl) begin
            if (m_pv) m_comm = m_pend;
            if (wr) begin
                m_pend = mg; m_pv = 1'b1;
            end else begin
                m_pv = 1'b0;
            end
        end

        @(posedge clk);
        @(negedge clk);
`ifdef FLAG_BYPASS_EN
        exp_flags = m_pv ? m_pend : m_comm;
        exp_haz   = 1'b0;
`else
        exp_flags = m_comm;
        exp_haz   = m_pv;
`endif
        check({tag, "_flags"}, Flags, exp_flags);
        check({tag, "_hazard"}, {3'b000, FlagsHazard}, {3'b000, exp_haz});
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, ALU_ADD, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0]  r_op, r_fw;
        logic [31:0] r_a, r_b;
        reset = 1'b1; SrcA = '0; SrcB = '0; ALUResult = '0; ALUControl = ALU_ADD;
        FlagWrite = 2'b00; CondEx = 1'b0; Valid = 1'b0; Stall = 1'b0; Flush = 1'b0;
        @(negedge clk);

        // Reset held two cycles
        step("rst0", 1'b1, ALU_ADD, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b1, ALU_ADD, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_value", Flags, 4'b0000);

        // SUB 5-5 -> Z,C
        step("sub55_cap", 1'b0, ALU_SUB, 32'd5, 32'd5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        idle("sub55_commit");
        check("sub55_value", Flags, 4'b0110);

        // ADD signed overflow, then AND result 0 keeping C,V
        step("addov_cap", 1'b0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        idle("addov_commit");
        check("addov_value", Flags, 4'b1001);
        step("and0_cap", 1'b0, ALU_AND, 32'h0000_00F0, 32'h0000_000F, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        idle("and0_commit");
        check("and0_value", Flags, 4'b0101);

        // Suppressed writes
        step("condex0", 1'b0, ALU_SUB, 32'd3, 32'd5, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        step("valid0", 1'b0, ALU_SUB, 32'd3, 32'd5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("suppress_idle");
        check("suppress_value", Flags, 4'b0101);

        // Capture then flush the next cycle
        step("flush_cap", 1'b0, ALU_SUB, 32'd3, 32'd5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("flush", 1'b0, ALU_ADD, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("flush_idle");
        check("flush_value", Flags, 4'b0101);

        // Stall three cycles in PEND, then release
        step("stall_cap", 1'b0, ALU_SUB, 32'd3, 32'd5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 1'b0, ALU_ADD, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("stall_release");
        check("stall_value", Flags, 4'b1000);

        // Flush together with Stall while pending; back-to-back captures
        step("fs_cap", 1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("fs_both", 1'b0, ALU_ADD, 32'd0, 32'd0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        idle("fs_idle");
        step("b2b_a", 1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("b2b_b", 1'b0, ALU_ORR, 32'h8000_0000, 32'd0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        idle("b2b_c");
        idle("b2b_d");

        // Reset while an update is pending
        step("mrst_cap", 1'b0, ALU_SUB, 32'd1, 32'd2, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("mrst", 1'b1, ALU_ADD, 32'd0, 32'd0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mrst_value", Flags, RST);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_fw = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: r_a = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
                1: r_a = 32'h8000_0000 + 32'($urandom_range(0, 3));
                default: r_a = $urandom;
            endcase
            r_b = ($urandom_range(0, 4) == 0) ? r_a : $urandom;
            step("rand", ($urandom_range(0, 63) == 0), r_op, r_a, r_b, r_fw,
                 ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
